// File: rtl/cordic_div_if.sv
// Operand/result bundle for the pipelined CORDIC divider.
// The master drives operands and receives quotients; the slave is the divider.
interface cordic_div_if #(
    parameter int WORD_SZ = 20,
    parameter int TAG_W   = 4
);
    logic                      in_valid;
    logic signed [WORD_SZ-1:0] y_in;
    logic signed [WORD_SZ-1:0] x_in;
    logic [TAG_W-1:0]          tag_in;
    logic                      out_valid;
    logic signed [WORD_SZ-1:0] z_out;
    logic [TAG_W-1:0]          tag_out;
    logic                      div_zero;
    logic                      ovf;

    modport master (
        output in_valid, y_in, x_in, tag_in,
        input  out_valid, z_out, tag_out, div_zero, ovf
    );

    modport slave (
        input  in_valid, y_in, x_in, tag_in,
        output out_valid, z_out, tag_out, div_zero, ovf
    );
endinterface

// File: rtl/cordic_div_pipe.sv
// Pipelined signed linear-mode CORDIC divider z = y/x in Q(FRAC_SZ), one result per clock.
// Works on magnitudes, reapplies the sign at the end; flags divide-by-zero and overflow.
module cordic_div_pipe #(
    parameter int WORD_SZ   = 20,
    parameter int FRAC_SZ   = 16,
    parameter int NUM_STAGE = FRAC_SZ + 1,
    parameter int TAG_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    cordic_div_if.slave bus
);
    localparam int MW = WORD_SZ + 1;
    localparam int RW = WORD_SZ + 3;
    localparam int ZW = WORD_SZ + 1;
    localparam logic signed [ZW-1:0]      SAT  = (ZW'(1) << (FRAC_SZ + 1)) - ZW'(1);
    localparam logic signed [WORD_SZ-1:0] SATW = WORD_SZ'(SAT);

    if (NUM_STAGE < 4 || NUM_STAGE > FRAC_SZ + 1) begin : g_bad_stage
        $error("cordic_div_pipe: NUM_STAGE must lie in 4..FRAC_SZ+1");
    end

    typedef struct packed {
        logic signed [RW-1:0] r;
        logic signed [ZW-1:0] z;
        logic [MW-1:0]        ax;
        logic                 neg;
        logic                 dzero;
        logic                 ov;
        logic                 ypos;
        logic                 yneg;
        logic [TAG_W-1:0]     tag;
    } stage_t;

    // pipe_q[0] is the input stage, pipe_q[i+1] holds the state after iteration i
    stage_t               pipe_q [NUM_STAGE+1];
    logic [NUM_STAGE+1:0] vld_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= {vld_pipe_q[NUM_STAGE:0], bus.in_valid};
    end

    logic signed [MW-1:0] ys, xs;
    logic [MW-1:0]        ay, ax;
    logic                 dz_in, ov_in;

    // One extra bit keeps |-2^(WORD_SZ-1)| exact
    always_comb begin
        ys    = {bus.y_in[WORD_SZ-1], bus.y_in};
        xs    = {bus.x_in[WORD_SZ-1], bus.x_in};
        ay    = ys[MW-1] ? -ys : ys;
        ax    = xs[MW-1] ? -xs : xs;
        dz_in = (bus.x_in == '0);
        ov_in = !dz_in && ({1'b0, ay} >= {ax, 1'b0});
    end

    always_ff @(posedge clk) begin
        pipe_q[0].r     <= $signed({2'b00, ay});
        pipe_q[0].z     <= '0;
        pipe_q[0].ax    <= ax;
        pipe_q[0].neg   <= bus.y_in[WORD_SZ-1] ^ bus.x_in[WORD_SZ-1];
        pipe_q[0].dzero <= dz_in;
        pipe_q[0].ov    <= ov_in;
        pipe_q[0].ypos  <= !bus.y_in[WORD_SZ-1] && (bus.y_in != '0);
        pipe_q[0].yneg  <= bus.y_in[WORD_SZ-1];
        pipe_q[0].tag   <= bus.tag_in;
    end

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage
        localparam logic signed [ZW-1:0] STEP = $signed(ZW'(1) << (FRAC_SZ - i));
        logic signed [RW-1:0] dx;

        assign dx = $signed({2'b00, pipe_q[i].ax >> i});

        // Non-restoring step: the residual sign picks the direction
        always_ff @(posedge clk) begin
            pipe_q[i+1] <= pipe_q[i];
            if (pipe_q[i].r[RW-1]) begin
                pipe_q[i+1].r <= pipe_q[i].r + dx;
                pipe_q[i+1].z <= pipe_q[i].z - STEP;
            end else begin
                pipe_q[i+1].r <= pipe_q[i].r - dx;
                pipe_q[i+1].z <= pipe_q[i].z + STEP;
            end
        end
    end

    stage_t                    fin;
    logic signed [ZW-1:0]      zc, zres;
    logic signed [WORD_SZ-1:0] z_d;
    logic                      unused_fin;

    assign fin        = pipe_q[NUM_STAGE];
    assign unused_fin = ^{fin.r, fin.ax};

    // Clamp before negating so the two signs stay exact mirrors
    always_comb begin
        zc = fin.z;
        if (fin.z[ZW-1])     zc = '0;
        else if (fin.z > SAT) zc = SAT;
        zres = fin.neg ? -zc : zc;
        z_d  = WORD_SZ'(zres);
        if (fin.dzero)   z_d = fin.ypos ? SATW : (fin.yneg ? -SATW : '0);
        else if (fin.ov) z_d = fin.neg ? -SATW : SATW;
    end

    logic signed [WORD_SZ-1:0] z_q;
    logic [TAG_W-1:0]          tag_q;
    logic                      dz_q, ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q   <= '0;
            tag_q <= '0;
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (vld_pipe_q[NUM_STAGE]) begin
            z_q   <= z_d;
            tag_q <= fin.tag;
            dz_q  <= fin.dzero;
            ovf_q <= fin.ov;
        end
    end

    assign bus.out_valid = vld_pipe_q[NUM_STAGE+1];
    assign bus.z_out     = z_q;
    assign bus.tag_out   = tag_q;
    assign bus.div_zero  = dz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cordic_div_pipe.sv
// Directed and random stimulus for cordic_div_pipe, checked against an arithmetic
// reference through a scoreboard queue.
module tb_cordic_div_pipe;
    localparam int    LAT = 19;
    localparam longint SAT = 64'h1FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cordic_div_if #(.WORD_SZ(20), .TAG_W(4)) bus ();

    cordic_div_pipe #(.WORD_SZ(20), .FRAC_SZ(16), .NUM_STAGE(17), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [19:0] y;
        logic signed [19:0] x;
        logic [3:0]         tag;
    } exp_t;

    exp_t               q[$];
    logic [LAT-1:0]     vhist = '0;
    logic signed [19:0] last_z [16];

    always @(posedge clk) vhist <= rst ? '0 : {vhist[LAT-2:0], bus.in_valid};

    task automatic chk(input string name, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
        end
    endtask

    task automatic check_txn(input exp_t e);
        longint y, x, ay, ax, zo, zexp, err;
        logic   dz, ov;
        y  = longint'($signed(e.y));
        x  = longint'($signed(e.x));
        zo = longint'($signed(bus.z_out));
        ay = (y < 0) ? -y : y;
        ax = (x < 0) ? -x : x;
        dz = (x == 0);
        ov = !dz && (ay >= 2 * ax);
        chk("tag_out", longint'(bus.tag_out), longint'(e.tag));
        chk("div_zero", longint'(bus.div_zero), longint'(dz));
        chk("ovf", longint'(bus.ovf), longint'(ov));
        if (dz || ov) begin
            if (dz) zexp = (y > 0) ? SAT : ((y < 0) ? -SAT : 0);
            else    zexp = ((y < 0) != (x < 0)) ? -SAT : SAT;
            chk(dz ? "z_divzero" : "z_ovf", zo, zexp);
        end else begin
            // |z/2^16 - y/x| <= 2 LSB  <=>  |z*x - y*2^16| <= 2|x|
            err = zo * x - y * 65536;
            checks++;
            assert (err <= 2 * ax && err >= -2 * ax) else begin
                errors++;
                $error("FAIL z_tol: tag=%0d y=%0d x=%0d observed z=%0d expected within 2 LSB of %0d",
                       e.tag, y, x, zo, (y * 65536) / x);
            end
        end
        last_z[e.tag] = bus.z_out;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("out_valid_pattern", longint'(bus.out_valid), longint'(vhist[LAT-1]));
        if (bus.out_valid) begin
            chk("sb_nonempty", longint'(q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check_txn(e);
            end
        end
    end

    task automatic drive(input logic v, input logic signed [19:0] y, input logic signed [19:0] x,
                         input logic [3:0] t);
        exp_t e;
        @(posedge clk); #1;
        bus.in_valid = v;
        bus.y_in     = y;
        bus.x_in     = x;
        bus.tag_in   = t;
        if (v) begin
            e.y = y; e.x = x; e.tag = t;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_in_budget", longint'(q.size() == 0), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic signed [19:0] ry, rx;
        int sel, sent;
        bus.in_valid = 1'b0;
        bus.y_in = '0;
        bus.x_in = '0;
        bus.tag_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_z_out", longint'($signed(bus.z_out)), 0);
        chk("rst_tag_out", longint'(bus.tag_out), 0);
        chk("rst_div_zero", longint'(bus.div_zero), 0);
        chk("rst_ovf", longint'(bus.ovf), 0);

        // 1.0 / 2.0
        drive(1'b1, 20'sh10000, 20'sh20000, 4'd3);
        drain();
        chk("half_z_window", longint'($signed(last_z[3]) >= 20'sh07FFE && $signed(last_z[3]) <= 20'sh08002), 1);

        // sign symmetry: -1.5/1 and 1.5/-1 back to back
        drive(1'b1, -20'sh18000, 20'sh10000, 4'd5);
        drive(1'b1, 20'sh18000, -20'sh10000, 4'd6);
        drain();
        chk("sign_symmetry", longint'($signed(last_z[6])), longint'($signed(last_z[5])));

        // divide by zero, then overflow
        drive(1'b1, 20'sd5, 20'sd0, 4'd7);
        drive(1'b1, -20'sd5, 20'sd0, 4'd8);
        drive(1'b1, 20'sd0, 20'sd0, 4'd9);
        drive(1'b1, 20'sh30000, 20'sh10000, 4'd10);
        drive(1'b1, -20'sh80000, 20'sd1, 4'd11);
        drain();

        // random stream with bubbles
        sent = 0;
        while (sent < 1000) begin
            if ($urandom_range(0, 9) < 3) begin
                drive(1'b0, 20'($urandom()), 20'($urandom()), 4'($urandom()));
            end else begin
                ry  = 20'($urandom());
                sel = $urandom_range(0, 9);
                if (sel == 0) rx = '0;
                else if (sel == 1) begin
                    rx = 20'($urandom_range(1, 255));
                    ry = 20'($urandom_range(1024, 20'h7FFFF));
                    if ($urandom_range(0, 1) == 1) rx = -rx;
                    if ($urandom_range(0, 1) == 1) ry = -ry;
                end else if (sel == 2) rx = -20'sh80000;
                else if (sel <= 5) rx = 20'($urandom_range(1, 7)) << 16;
                else rx = 20'($urandom_range(8, 15)) << 15;
                if (sel >= 3 && $urandom_range(0, 1) == 1) rx = -rx;
                drive(1'b1, ry, rx, 4'($urandom()));
                sent++;
            end
        end
        drain();

        // reset with ten transactions in flight
        for (int n = 0; n < 10; n++) drive(1'b1, 20'sh10000, 20'sh20000, 4'(n));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_z_out", longint'($signed(bus.z_out)), 0);
        chk("midrst_tag_out", longint'(bus.tag_out), 0);
        drive(1'b1, -20'sh10000, 20'sh20000, 4'd12);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
